load_extract_unit: RTL and testbench

LOAD_EXTRACT_UNIT -- requirements
Module: load_extract_unit

---
 rtl/load_extract_unit.sv | 127 ++++++++++++
 tb/tb_load_extract_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_extract_unit.sv
// Load extraction unit: issues one word read per RV32 load and returns
// the byte/half/word result sign- or zero-extended, with alignment and ack-timeout faults.
module load_extract_unit #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_en,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        load_fault,
   output logic        stall
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE,
      FAULT
   } state_t;

   localparam logic [7:0] LAST_CNT = 8'(ACK_TIMEOUT - 1);

   state_t      state;
   state_t      state_n;
   logic [7:0]  cnt;
   logic [31:0] addr_q;
   logic [2:0]  funct3_q;
   logic        req_ok;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] ext_data;

   // Legal funct3 with natural alignment for its access size
   always_comb begin
      req_ok = 1'b0;
      case (funct3)
         3'b000, 3'b100: req_ok = 1'b1;
         3'b001, 3'b101: req_ok = ~addr[0];
         3'b010:         req_ok = (addr[1:0] == 2'b00);
         default:        req_ok = 1'b0;
      endcase
   end

   always_comb begin
      byte_v = mem_rdata[7:0];
      case (addr_q[1:0])
         2'b00: byte_v = mem_rdata[7:0];
         2'b01: byte_v = mem_rdata[15:8];
         2'b10: byte_v = mem_rdata[23:16];
         2'b11: byte_v = mem_rdata[31:24];
         default: byte_v = mem_rdata[7:0];
      endcase
      half_v = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   end

   always_comb begin
      ext_data = mem_rdata;
      case (funct3_q)
         3'b000:  ext_data = {{24{byte_v[7]}}, byte_v};
         3'b100:  ext_data = {24'd0, byte_v};
         3'b001:  ext_data = {{16{half_v[15]}}, half_v};
         3'b101:  ext_data = {16'd0, half_v};
         default: ext_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 8'd0;
         addr_q    <= 32'd0;
         funct3_q  <= 3'd0;
         load_data <= 32'd0;
      end else begin
         state <= state_n;
         if (state == IDLE && load_en) begin
            addr_q   <= addr;
            funct3_q <= funct3;
            cnt      <= 8'd0;
         end else if (state == WAIT && !mem_ack) begin
            cnt <= cnt + 8'd1;
         end
         if (state == WAIT && mem_ack) begin
            load_data <= ext_data;
         end
      end
   end

   always_comb begin
      state_n    = state;
      mem_read   = 1'b0;
      load_valid = 1'b0;
      load_fault = 1'b0;
      stall      = 1'b0;
      mem_addr   = {addr_q[31:2], 2'b00};
      case (state)
         IDLE: begin
            stall = load_en;
            if (load_en) state_n = req_ok ? WAIT : FAULT;
         end
         WAIT: begin
            mem_read = 1'b1;
            stall    = 1'b1;
            // A late ack still wins over the timeout in its final cycle
            if (mem_ack)              state_n = DONE;
            else if (cnt == LAST_CNT) state_n = FAULT;
         end
         DONE: begin
            load_valid = 1'b1;
            state_n    = IDLE;
         end
         FAULT: begin
            load_fault = 1'b1;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_load_extract_unit.sv
// Self-checking bench for load_extract_unit: scoreboarded loads,
// alignment/illegal faults, ack timeout, reset abort and back-to-back loads.
module tb_load_extract_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic [31:0] load_data;
   logic        load_valid;
   logic        load_fault;
   logic        stall;

   typedef struct {
      bit          fault;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] last_data;

   always #5 clk = ~clk;

   load_extract_unit #(.ACK_TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_en),
      .funct3    (funct3),
      .addr      (addr),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .mem_addr  (mem_addr),
      .mem_read  (mem_read),
      .load_data (load_data),
      .load_valid(load_valid),
      .load_fault(load_fault),
      .stall     (stall)
   );

   function automatic logic [31:0] model_ext(input logic [2:0] f3,
                                             input logic [31:0] a,
                                             input logic [31:0] r);
      logic [31:0] sh;
      logic [15:0] h;
      sh = r >> (8 * a[1:0]);
      h  = a[1] ? r[31:16] : r[15:0];
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b001:  return {{16{h[15]}}, h};
         3'b101:  return {16'd0, h};
         default: return r;
      endcase
   endfunction

   // Drives one load and watches the DUT until a result pulse; no checking here
   task automatic run_load(input logic [2:0] f3, input logic [31:0] a,
                           input int ack_after, input logic [31:0] rdata,
                           output bit got_v, output bit got_f,
                           output int lat, output logic [31:0] d,
                           output int rd, output bit st_req,
                           output bit st_end, output logic [31:0] maddr);
      got_v = 0; got_f = 0; lat = -1; d = 'x; rd = 0;
      st_end = 1'b1; maddr = 'x;
      @(negedge clk);
      funct3 = f3; addr = a; load_en = 1'b1;
      #1 st_req = stall;
      @(posedge clk);
      #1 load_en = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (load_valid || load_fault) begin
            got_v = load_valid; got_f = load_fault;
            d = load_data; lat = c; st_end = stall;
            break;
         end
         if (mem_read) begin
            rd++;
            maddr = mem_addr;
            if (rd - 1 == ack_after) begin
               mem_ack = 1'b1; mem_rdata = rdata;
            end
         end
      end
      mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; load_en = 1'b0; funct3 = 3'd0; addr = 32'd0;
      mem_rdata = 32'd0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if ({mem_read, load_valid, load_fault, stall} !== 4'b0000) begin
         n_errors++;
         $display("FAIL reset_ctrl got %b want 0000",
                  {mem_read, load_valid, load_fault, stall});
      end
      n_checks++;
      if (load_data !== 32'd0 || mem_addr !== 32'd0) begin
         n_errors++;
         $display("FAIL reset_data got data=%h addr=%h want 0", load_data, mem_addr);
      end
      last_data = 32'd0;
   endtask

   task automatic test_byte_loads();
      bit v, f, sr, se; int lat, rd; logic [31:0] d, ma; exp_t e;
      sb.push_back('{fault: 0, data: 32'hFFFFFF80});
      run_load(3'b000, 32'h1003, 0, 32'h80112233, v, f, lat, d, rd, sr, se, ma);
      e = sb.pop_front();
      n_checks++;
      if (!v || f || d !== e.data) begin
         n_errors++;
         $display("FAIL lb got v=%0b f=%0b d=%h want data %h", v, f, d, e.data);
      end
      n_checks++;
      if (lat !== 2 || sr !== 1'b1) begin
         n_errors++;
         $display("FAIL lb_latency got lat=%0d stall=%0b want 2 1", lat, sr);
      end
      n_checks++;
      if (ma !== 32'h1000 || se !== 1'b0) begin
         n_errors++;
         $display("FAIL lb_memaddr got %h stall_end=%0b want 00001000 0", ma, se);
      end
      sb.push_back('{fault: 0, data: 32'h00000080});
      run_load(3'b100, 32'h1003, 0, 32'h80112233, v, f, lat, d, rd, sr, se, ma);
      e = sb.pop_front();
      n_checks++;
      if (!v || d !== e.data) begin
         n_errors++;
         $display("FAIL lbu got v=%0b d=%h want %h", v, d, e.data);
      end
      last_data = e.data;
   endtask

   task automatic test_half_loads();
      bit v, f, sr, se; int lat, rd; logic [31:0] d, ma; exp_t e;
      sb.push_back('{fault: 0, data: 32'h0000BEEF});
      run_load(3'b101, 32'h1002, 0, 32'hBEEF1234, v, f, lat, d, rd, sr, se, ma);
      e = sb.pop_front();
      n_checks++;
      if (!v || d !== e.data) begin
         n_errors++;
         $display("FAIL lhu got v=%0b d=%h want %h", v, d, e.data);
      end
      sb.push_back('{fault: 0, data: 32'hFFFFBEEF});
      run_load(3'b001, 32'h1002, 1, 32'hBEEF1234, v, f, lat, d, rd, sr, se, ma);
      e = sb.pop_front();
      n_checks++;
      if (!v || d !== e.data || lat !== 3) begin
         n_errors++;
         $display("FAIL lh got v=%0b d=%h lat=%0d want %h lat 3", v, d, lat, e.data);
      end
      sb.push_back('{fault: 0, data: 32'h00001234});
      run_load(3'b101, 32'h1000, 0, 32'hBEEF1234, v, f, lat, d, rd, sr, se, ma);
      e = sb.pop_front();
      n_checks++;
      if (!v || d !== e.data) begin
         n_errors++;
         $display("FAIL lhu_low got v=%0b d=%h want %h", v, d, e.data);
      end
      sb.push_back('{fault: 0, data: 32'hCAFE0102});
      run_load(3'b010, 32'h1004, 0, 32'hCAFE0102, v, f, lat, d, rd, sr, se, ma);
      e = sb.pop_front();
      n_checks++;
      if (!v || d !== e.data) begin
         n_errors++;
         $display("FAIL lw got v=%0b d=%h want %h", v, d, e.data);
      end
      last_data = e.data;
   endtask

   task automatic test_faults();
      bit v, f, sr, se; int lat, rd; logic [31:0] d, ma; exp_t e;
      logic [2:0]  f3s[3] = '{3'b010, 3'b011, 3'b001};
      logic [31:0] as[3]  = '{32'h1002, 32'h1000, 32'h1001};
      for (int i = 0; i < 3; i++) begin
         sb.push_back('{fault: 1, data: last_data});
         run_load(f3s[i], as[i], 0, 32'h5555AAAA, v, f, lat, d, rd, sr, se, ma);
         e = sb.pop_front();
         n_checks++;
         if (v || !f || lat !== 1 || rd !== 0) begin
            n_errors++;
            $display("FAIL fault%0d got v=%0b f=%0b lat=%0d reads=%0d want fault lat 1 reads 0",
                     i, v, f, lat, rd);
         end
         n_checks++;
         if (d !== e.data || sr !== 1'b1) begin
            n_errors++;
            $display("FAIL fault%0d_data got %h stall=%0b want %h 1", i, d, sr, e.data);
         end
      end
   endtask

   task automatic test_timeout();
      bit v, f, sr, se; int lat, rd; logic [31:0] d, ma; exp_t e;
      sb.push_back('{fault: 1, data: last_data});
      run_load(3'b010, 32'h2000, -1, 32'h0, v, f, lat, d, rd, sr, se, ma);
      e = sb.pop_front();
      n_checks++;
      if (v || !f || rd !== 16 || lat !== 17) begin
         n_errors++;
         $display("FAIL timeout got v=%0b f=%0b reads=%0d lat=%0d want fault 16 17",
                  v, f, rd, lat);
      end
      n_checks++;
      if (d !== e.data || se !== 1'b0) begin
         n_errors++;
         $display("FAIL timeout_data got %h stall=%0b want %h 0", d, se, e.data);
      end
      sb.push_back('{fault: 0, data: 32'h13579BDF});
      run_load(3'b010, 32'h2000, 15, 32'h13579BDF, v, f, lat, d, rd, sr, se, ma);
      e = sb.pop_front();
      n_checks++;
      if (!v || f || d !== e.data || rd !== 16 || lat !== 17) begin
         n_errors++;
         $display("FAIL ack_last got v=%0b f=%0b d=%h reads=%0d lat=%0d want %h 16 17",
                  v, f, d, rd, lat, e.data);
      end
      last_data = e.data;
   endtask

   task automatic test_reset_in_wait();
      int bad = 0;
      @(negedge clk);
      funct3 = 3'b010; addr = 32'h4000; load_en = 1'b1;
      @(posedge clk);
      #1 load_en = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if ({mem_read, load_valid, load_fault, stall} !== 4'b0000) bad++;
         if (load_data !== 32'd0 || mem_addr !== 32'd0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_errors++;
         $display("FAIL rst_in_wait got %0d nonzero samples want 0", bad);
      end
      last_data = 32'd0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] as[3] = '{32'h3000, 32'h3001, 32'h3006};
      logic [31:0] rs[3] = '{32'hA1B2C3D4, 32'h11223344, 32'h55667788};
      int valids = 0; exp_t e;
      @(negedge clk);
      funct3 = 3'b100; load_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         addr = as[i];
         sb.push_back('{fault: 0, data: model_ext(3'b100, as[i], rs[i])});
         @(negedge clk);
         addr = 32'h7FF3;
         mem_ack = 1'b1; mem_rdata = rs[i];
         n_checks++;
         if (mem_read !== 1'b1 || mem_addr !== {as[i][31:2], 2'b00}) begin
            n_errors++;
            $display("FAIL b2b%0d_wait got rd=%0b addr=%h want 1 %h",
                     i, mem_read, mem_addr, {as[i][31:2], 2'b00});
         end
         @(negedge clk);
         mem_ack = 1'b0; mem_rdata = 32'h0;
         e = sb.pop_front();
         if (load_valid) valids++;
         n_checks++;
         if (load_valid !== 1'b1 || load_data !== e.data) begin
            n_errors++;
            $display("FAIL b2b%0d got v=%0b d=%h want 1 %h", i, load_valid, load_data, e.data);
         end
         @(negedge clk);
      end
      load_en = 1'b0;
      n_checks++;
      if (valids !== 3) begin
         n_errors++;
         $display("FAIL b2b_count got %0d want 3", valids);
      end
   endtask

   initial begin
      test_reset();
      test_byte_loads();
      test_half_loads();
      test_faults();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
